fde_sequencer: RTL
==================

Name: fde_sequencer

Overview:
- Multi-cycle control FSM that sequences the simple_cpu fetch/decode/execute datapath: PC, instruction register, ALU and regA.
- Issues instruction-memory reads and tolerates wait states, with a timeout.
- Decodes the opcode and drives one-cycle strobes for datapath register updates.
- Supports free-run, single-step and halt; counts retired instructions.

Parameters:
- OPW, 4: opcode field width.
- TIMEOUT, 15: maximum MEMWAIT cycles before a fetch fault.
- CNTW, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- run  input  1  enable; high lets the FSM leave IDLE and keep fetching.
- step_mode  input  1  high means pause in STEPWAIT after each instruction.
- step  input  1  one-cycle pulse that releases STEPWAIT.
- mem_ready  input  1  instruction memory data valid this cycle.
- opcode  input  OPW  opcode field of the instruction memory output.
- mem_rd  output  1  instruction read request.
- ir_load  output  1  load instruction register.
- pc_inc  output  1  PC <= PC+1.
- pc_load  output  1  PC <= jump target (JMP).
- rega_we  output  1  regA write enable.
- alu_op  output  2  0 PASS, 1 ADD, 2 SUB, 3 unused.
- retire  output  1  pulse when an instruction completes EXECUTE.
- illegal  output  1  pulse for an undefined opcode in EXECUTE.
- fault  output  1  sticky fetch-timeout flag.
- halted  output  1  high in HALT state.
- state  output  3  current state encoding.
- instr_count  output  CNTW  retired-instruction count.

Behaviour:
- Clock and reset: one clock; rst is asynchronous, active-high.
- Reset values:
  - state=IDLE(0), instr_count=0, fault=0, internal opcode latch=0, wait counter=0.
  - All strobes 0 while rst is high and in IDLE.
- State encoding: IDLE 0, FETCH 1, MEMWAIT 2, DECODE 3, EXECUTE 4, STEPWAIT 5, HALT 6. Codes 7 and above go to IDLE.
- Output decoding: strobes are decoded combinationally from state, mem_ready and the latched opcode. Counter and flags are registered.
- IDLE: if run=1, go to FETCH; otherwise stay.
- FETCH:
  - mem_rd=1.
  - If mem_ready=1: ir_load=1, pc_inc=1, latch opcode, go to DECODE.
  - Otherwise clear the wait counter and go to MEMWAIT.
- MEMWAIT:
  - mem_rd=1; the wait counter increments each cycle.
  - If mem_ready=1: ir_load=1, pc_inc=1, latch opcode, go to DECODE.
  - Else, if the counter reaches TIMEOUT: fault<=1, go to HALT.
  - mem_ready has priority over timeout in the same cycle.
- DECODE: one cycle, no strobes, go to EXECUTE.
- EXECUTE (exactly one cycle):
  - 0000 NOP: no writes.
  - 0001 LOAD: rega_we=1, alu_op=PASS.
  - 0010 ADD: rega_we=1, alu_op=ADD.
  - 0011 SUB: rega_we=1, alu_op=SUB.
  - 0100 JMP: pc_load=1 (overrides the pc_inc already applied).
  - 1111 HALT: no writes.
  - Any other opcode: illegal=1, no writes, treated as NOP.
  - retire=1 and instr_count increments for every opcode, including HALT and illegal. The counter wraps from 2^CNTW-1 to 0.
- Next state from EXECUTE, in priority order:
  1. opcode HALT: go to HALT.
  2. run=0: go to IDLE.
  3. step_mode=1: go to STEPWAIT.
  4. Otherwise go to FETCH.
- STEPWAIT:
  - step=1 or step_mode=0: go to FETCH.
  - run=0: go to IDLE, with priority over step.
- HALT: terminal; no strobes; halted=1; only rst exits.
- run deasserted mid-instruction (FETCH, MEMWAIT or DECODE): the current instruction completes; the return to IDLE happens from EXECUTE.
- Latency: with a zero-wait memory, 3 cycles per instruction (FETCH, DECODE, EXECUTE). Each MEMWAIT cycle adds 1 cycle.
- Exclusivity: never more than one of pc_inc and pc_load asserted in a cycle.
- Reset mid-operation: asynchronous return to IDLE; fault and instr_count are cleared.

Test Plan:
- Reset then run=1, mem_ready tied 1, program LOAD, ADD, SUB, NOP: states cycle 1,3,4 per instruction; rega_we high on EXECUTE of the first three only; alu_op 0,1,2; instr_count=4 after 12 cycles.
- JMP opcode 0100 with zero-wait memory: pc_inc in FETCH, pc_load alone in EXECUTE, then FETCH; retire=1 once.
- mem_ready delayed 3 cycles: MEMWAIT lasts 3 cycles with mem_rd held 1; then ir_load+pc_inc; instruction takes 6 cycles. mem_ready never asserted: after TIMEOUT=15 MEMWAIT cycles, fault=1, state=6, halted=1, no further mem_rd.
- step_mode=1: after each EXECUTE, state=5 with no mem_rd until a step pulse; step at cycle k gives FETCH at k+1. Dropping run while in STEPWAIT gives IDLE.
- Opcode 1010 gives illegal=1 for one cycle with no write and count +1. Opcode 1111 gives HALT, and halted stays 1 for 20 cycles with run=1.
- Assert rst asynchronously mid-MEMWAIT: state=0, fault=0 and instr_count=0 immediately, before the next edge. Counter wrap: with CNTW=4, retire 17 instructions and instr_count=1.

Source files
------------

// File: rtl/fde_sequencer.sv
// ---------------------------------------------------------------------------
// fde_sequencer
// Multi-cycle fetch/decode/execute control FSM for the simple_cpu datapath.
// It issues instruction reads, tolerates memory wait states with a timeout,
// decodes the latched opcode, and drives one-cycle strobes to the PC,
// instruction register, ALU and regA. It supports free-run, single-step and
// halt modes, and it counts retired instructions.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   run          enable: leave IDLE and keep fetching
//   step_mode    pause in STEPWAIT after each instruction
//   step         one-cycle pulse that releases STEPWAIT
//   mem_ready    instruction memory data valid this cycle
//   opcode       opcode field of the instruction memory output
//   mem_rd       instruction read request
//   ir_load      load instruction register
//   pc_inc       PC <= PC + 1
//   pc_load      PC <= jump target
//   rega_we      regA write enable
//   alu_op       0 PASS, 1 ADD, 2 SUB
//   retire       pulse when an instruction completes EXECUTE
//   illegal      pulse for an undefined opcode in EXECUTE
//   fault        sticky fetch-timeout flag
//   halted       high in HALT
//   state        current state encoding
//   instr_count  retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module fde_sequencer #(
    parameter int OPW     = 4,
    parameter int TIMEOUT = 15,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            step_mode,
    input  logic            step,
    input  logic            mem_ready,
    input  logic [OPW-1:0]  opcode,
    output logic            mem_rd,
    output logic            ir_load,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            rega_we,
    output logic [1:0]      alu_op,
    output logic            retire,
    output logic            illegal,
    output logic            fault,
    output logic            halted,
    output logic [2:0]      state,
    output logic [CNTW-1:0] instr_count
);

    localparam int WCW = $clog2(TIMEOUT + 1);

    localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
    localparam logic [OPW-1:0] OP_LOAD = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(3);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(4);
    localparam logic [OPW-1:0] OP_HALT = {OPW{1'b1}};

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_SUB  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_MEMWAIT  = 3'd2,
        S_DECODE   = 3'd3,
        S_EXECUTE  = 3'd4,
        S_STEPWAIT = 3'd5,
        S_HALT     = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [OPW-1:0]   r_opcode;
    logic [WCW-1:0]   r_wait_cnt;
    logic             r_fault;
    logic [CNTW-1:0]  r_instr_count;
    logic             w_timeout;
    logic             w_set_fault;

    // The current MEMWAIT cycle is the TIMEOUT-th one when the counter
    // (cleared in FETCH) still holds TIMEOUT-1.
    assign w_timeout = (r_wait_cnt == WCW'(TIMEOUT - 1));

    // -----------------------------------------------------------------------
    // State and datapath-control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_opcode      <= '0;
            r_wait_cnt    <= '0;
            r_fault       <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (ir_load) begin
                r_opcode <= opcode;
            end
            if (r_state == S_FETCH) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_MEMWAIT) begin
                r_wait_cnt <= r_wait_cnt + WCW'(1);
            end
            if (w_set_fault) begin
                r_fault <= 1'b1;
            end
            if (retire) begin
                r_instr_count <= r_instr_count + CNTW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state and strobe decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_set_fault  = 1'b0;
        mem_rd       = 1'b0;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        rega_we      = 1'b0;
        alu_op       = ALU_PASS;
        retire       = 1'b0;
        illegal      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_next = S_FETCH;
                end
            end

            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_load      = 1'b1;
                    pc_inc       = 1'b1;
                    w_state_next = S_DECODE;
                end else begin
                    w_state_next = S_MEMWAIT;
                end
            end

            S_MEMWAIT: begin
                mem_rd = 1'b1;
                // Data arriving in the last allowed cycle still wins.
                if (mem_ready) begin
                    ir_load      = 1'b1;
                    pc_inc       = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_timeout) begin
                    w_set_fault  = 1'b1;
                    w_state_next = S_HALT;
                end
            end

            S_DECODE: begin
                w_state_next = S_EXECUTE;
            end

            S_EXECUTE: begin
                retire = 1'b1;
                case (r_opcode)
                    OP_NOP:  ;
                    OP_LOAD: begin
                        rega_we = 1'b1;
                        alu_op  = ALU_PASS;
                    end
                    OP_ADD: begin
                        rega_we = 1'b1;
                        alu_op  = ALU_ADD;
                    end
                    OP_SUB: begin
                        rega_we = 1'b1;
                        alu_op  = ALU_SUB;
                    end
                    OP_JMP:  pc_load = 1'b1;
                    OP_HALT: ;
                    default: illegal = 1'b1;
                endcase

                if (r_opcode == OP_HALT) begin
                    w_state_next = S_HALT;
                end else if (!run) begin
                    w_state_next = S_IDLE;
                end else if (step_mode) begin
                    w_state_next = S_STEPWAIT;
                end else begin
                    w_state_next = S_FETCH;
                end
            end

            S_STEPWAIT: begin
                if (!run) begin
                    w_state_next = S_IDLE;
                end else if (step || !step_mode) begin
                    w_state_next = S_FETCH;
                end
            end

            S_HALT: begin
                w_state_next = S_HALT;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign fault       = r_fault;
    assign halted      = (r_state == S_HALT);
    assign state       = r_state;
    assign instr_count = r_instr_count;

endmodule
